// File: rtl/sram_rw0_pkg.sv
// Shared definitions for the RW0 SRAM initiator: controller states,
// response FIFO depth, the read credit limit and a pointer-wrap helper.
package sram_rw0_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int RESP_DEPTH   = 3;
    localparam int CREDIT_LIMIT = RESP_DEPTH;

    // Advance a FIFO pointer, wrapping after the last entry.
    function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
        return (ptr == 2'(RESP_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/sram_rw0_resp_fifo.sv
// Three-entry response FIFO holding returned read data until the
// consumer takes it. No bypass: data is visible the cycle after the push.
module sram_rw0_resp_fifo
    import sram_rw0_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [RESP_DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;

    // Storage array; contents are only observed through count, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps count steady.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head entry, forced to zero while empty so idle output is clean.
    always_comb begin
        head_data = '0;
        if (count != 2'd0) begin
            head_data = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/sram_rw0_initiator.sv
// Initiator for a single-port RW0 SRAM macro. Arbitrates a write and a
// read request channel round-robin onto the one port, returns read data
// through a credit-throttled response FIFO.
// Optional feature macro: SRAM_INIT_CLEAR_EN -- when defined, the whole
// array is written to zero after reset before requests are accepted.
module sram_rw0_initiator
    import sram_rw0_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    state_t          state;
    state_t          state_next;
    logic [ADDR_W:0] sweep_cnt;
    logic [ADDR_W:0] sweep_next;
    logic            pri_rd;
    logic            pri_next;
    logic            inflight;
    logic [1:0]      fifo_count;
    logic [2:0]      credits_used;
    logic            wr_elig;
    logic            rd_elig;
    logic            grant_wr;
    logic            grant_rd;
    logic            resp_pop;

    // Credits in use are entries already buffered plus the read still in the macro.
    always_comb begin
        credits_used = {1'b0, fifo_count} + {2'b00, inflight};
        wr_elig      = wr_valid;
        rd_elig      = rd_valid && (credits_used < 3'(CREDIT_LIMIT));
    end

    // Next state, round-robin grant and RW0 drive; everything is idle while reset is asserted.
    always_comb begin
        state_next = state;
        sweep_next = sweep_cnt;
        pri_next   = pri_rd;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        RW0_en     = 1'b0;
        RW0_wmode  = 1'b0;
        RW0_addr   = '0;
        RW0_wmask  = '0;
        RW0_wdata  = '0;
        if (reset_n) begin
            case (state)
                INIT: begin
`ifdef SRAM_INIT_CLEAR_EN
                    RW0_en     = 1'b1;
                    RW0_wmode  = 1'b1;
                    RW0_addr   = sweep_cnt[ADDR_W-1:0];
                    RW0_wmask  = '1;
                    RW0_wdata  = '0;
                    sweep_next = sweep_cnt + 1'b1;
                    if (sweep_next[ADDR_W]) begin
                        state_next = RUN;
                    end
`else
                    sweep_next = '0;
                    state_next = RUN;
`endif
                end
                RUN: begin
                    grant_wr = wr_elig && (!rd_elig || !pri_rd);
                    grant_rd = rd_elig && (!wr_elig ||  pri_rd);
                    wr_ready = grant_wr;
                    rd_ready = grant_rd;
                    if (grant_wr) begin
                        RW0_en    = 1'b1;
                        RW0_wmode = 1'b1;
                        RW0_addr  = wr_addr;
                        RW0_wmask = wr_mask;
                        RW0_wdata = wr_data;
                        pri_next  = 1'b1;
                    end else if (grant_rd) begin
                        RW0_en    = 1'b1;
                        RW0_wmode = 1'b0;
                        RW0_addr  = rd_addr;
                        pri_next  = 1'b0;
                    end
                end
                default: state_next = INIT;
            endcase
        end
    end

    // Controller registers; a read issued this cycle returns data next cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
            pri_rd    <= 1'b0;
            inflight  <= 1'b0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_next;
            pri_rd    <= pri_next;
            inflight  <= grant_rd;
        end
    end

    // Response side: occupancy drives resp_valid, handshake pops.
    always_comb begin
        resp_valid = (fifo_count != 2'd0);
        resp_pop   = resp_valid && resp_ready;
        init_done  = reset_n && (state == RUN);
    end

    sram_rw0_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (RW0_rdata),
        .pop       (resp_pop),
        .head_data (resp_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_rw0_initiator.sv
// Self-checking bench for sram_rw0_initiator with a behavioural RW0 macro.
// Expected read data comes from a shadow memory updated on observed
// accepts and is queued in a scoreboard, popped when responses leave.
// Honours SRAM_INIT_CLEAR_EN for the expected INIT behaviour.
module tb_sram_rw0_initiator;

    localparam int AW = 7;
    localparam int DW = 4;
`ifdef SRAM_INIT_CLEAR_EN
    localparam int INIT_CYCLE = 129;
`else
    localparam int INIT_CYCLE = 2;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] wr_mask = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          init_done;
    logic          RW0_en;
    logic          RW0_wmode;
    logic [AW-1:0] RW0_addr;
    logic [DW-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata;

    int checks = 0;
    int passed = 0;
    int cycle  = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_mem [2**AW];

    int            obs_cycle;
    logic          obs_wr_acc, obs_rd_acc, obs_rd_rdy, obs_wr_rdy, obs_resp;
    logic          obs_resp_valid, obs_init, obs_en;
    logic [DW-1:0] obs_resp_data;
    logic [AW-1:0] obs_addr;
    logic [3*DW+AW:0] obs_rw0_bus;

    always #5 clock = ~clock;

    sram_rw0_initiator #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .init_done  (init_done),
        .RW0_en     (RW0_en),
        .RW0_wmode  (RW0_wmode),
        .RW0_addr   (RW0_addr),
        .RW0_wmask  (RW0_wmask),
        .RW0_wdata  (RW0_wdata),
        .RW0_rdata  (RW0_rdata)
    );

    function automatic logic [DW-1:0] junk(input int a);
        return 4'(a) ^ 4'h5;
    endfunction

    // Behavioural RW0 macro: masked write, registered read data.
    logic          model_loaded = 1'b0;
    logic [DW-1:0] model_mem [2**AW];
    logic [DW-1:0] model_rdata = '0;
    assign RW0_rdata = model_rdata;

    always @(posedge clock) begin
        if (!model_loaded) begin
            for (int i = 0; i < 2**AW; i++) model_mem[i] <= junk(i);
            model_loaded <= 1'b1;
        end else if (RW0_en) begin
            if (RW0_wmode)
                model_mem[RW0_addr] <= (model_mem[RW0_addr] & ~RW0_wmask) | (RW0_wdata & RW0_wmask);
            else
                model_rdata <= model_mem[RW0_addr];
        end
    end

    // Advance one cycle: sample at the falling edge, record accepts, return just after the rising edge.
    task automatic step();
        @(negedge clock);
        obs_cycle      = cycle;
        obs_wr_rdy     = wr_ready;
        obs_rd_rdy     = rd_ready;
        obs_wr_acc     = wr_valid && wr_ready;
        obs_rd_acc     = rd_valid && rd_ready;
        obs_resp       = resp_valid && resp_ready;
        obs_resp_valid = resp_valid;
        obs_resp_data  = resp_data;
        obs_init       = init_done;
        obs_en         = RW0_en;
        obs_addr       = RW0_addr;
        obs_rw0_bus    = {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata};
        if (obs_wr_acc) exp_mem[wr_addr] = (exp_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        if (obs_rd_acc) sb.push_back(exp_mem[rd_addr]);
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle   = 1;
        sb.delete();
`ifdef SRAM_INIT_CLEAR_EN
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
`endif
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            ok = obs_init;
        end
    endtask

    task automatic issue_write(input int a, input logic [DW-1:0] d, input logic [DW-1:0] m, output bit ok);
        wr_valid = 1'b1;
        wr_addr  = 7'(a);
        wr_data  = d;
        wr_mask  = m;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = obs_wr_acc;
        end
        wr_valid = 1'b0;
    endtask

    task automatic issue_read(input int a, output bit ok);
        rd_valid = 1'b1;
        rd_addr  = 7'(a);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = obs_rd_acc;
        end
        rd_valid = 1'b0;
    endtask

    // Reset values while both request channels are asking.
    task automatic test_reset();
        reset_n    = 1'b0;
        wr_valid   = 1'b1;
        rd_valid   = 1'b1;
        resp_ready = 1'b1;
        step();
        step();
        checks++;
        if (obs_rw0_bus !== '0) $display("[TB] FAIL reset_rw0: got %h want 0", obs_rw0_bus);
        else passed++;
        checks++;
        if ({obs_wr_rdy, obs_rd_rdy} !== 2'b00) $display("[TB] FAIL reset_ready: got %b want 00", {obs_wr_rdy, obs_rd_rdy});
        else passed++;
        checks++;
        if ({obs_resp_valid, obs_resp_data, obs_init} !== '0) $display("[TB] FAIL reset_resp: got v=%b d=%h init=%b want 0", obs_resp_valid, obs_resp_data, obs_init);
        else passed++;
        resp_ready = 1'b0;
        do_reset();
    endtask

    // INIT duration, no accept before init_done, then reads of 0, 64, 127.
    task automatic test_init();
        int            init_cycle = -1;
        bit            early = 1'b0;
        bit            ok = 1'b0;
        bit            ok2, ok3;
        logic [DW-1:0] exp_d;
        rd_valid = 1'b1;
        rd_addr  = 7'd0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            if (obs_init && init_cycle < 0) init_cycle = obs_cycle;
            if ((obs_wr_rdy || obs_rd_rdy) && !obs_init) early = 1'b1;
            ok = obs_rd_acc;
        end
        rd_valid = 1'b0;
        checks++;
        if (init_cycle !== INIT_CYCLE) $display("[TB] FAIL init_cycle: got %0d want %0d", init_cycle, INIT_CYCLE);
        else passed++;
        checks++;
        if (early || !ok) $display("[TB] FAIL init_block: early=%b accepted=%b want early=0 accepted=1", early, ok);
        else passed++;
        issue_read(64, ok2);
        issue_read(127, ok3);
        checks++;
        if (!(ok2 && ok3)) $display("[TB] FAIL init_reads: accepted %b%b want 11", ok2, ok3);
        else passed++;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step();
            if (obs_resp) begin
                checks++;
                exp_d = sb.pop_front();
                if (obs_resp_data !== exp_d) $display("[TB] FAIL init_resp: got %h want %h", obs_resp_data, exp_d);
                else passed++;
            end
        end
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL init_drain: %0d responses missing want 0", sb.size());
        else passed++;
        resp_ready = 1'b0;
    endtask

    // Write then read the same address on the next cycle; check latency and data.
    task automatic test_write_read();
        bit            okw, okr;
        int            ta;
        logic [DW-1:0] exp_d;
        issue_write(5, 4'hA, 4'hF, okw);
        issue_read(5, okr);
        ta = obs_cycle;
        checks++;
        if (!(okw && okr)) $display("[TB] FAIL wr_rd_accept: got %b%b want 11", okw, okr);
        else passed++;
        step();
        checks++;
        if (obs_resp_valid !== 1'b0) $display("[TB] FAIL wr_rd_early: resp_valid=%b at T+%0d want 0", obs_resp_valid, obs_cycle - ta);
        else passed++;
        step();
        checks++;
        if (obs_resp_valid !== 1'b1 || obs_resp_data !== 4'hA) $display("[TB] FAIL wr_rd_latency: v=%b d=%h at T+%0d want v=1 d=a", obs_resp_valid, obs_resp_data, obs_cycle - ta);
        else passed++;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step();
            if (obs_resp) begin
                checks++;
                exp_d = sb.pop_front();
                if (obs_resp_data !== exp_d) $display("[TB] FAIL wr_rd_resp: got %h want %h", obs_resp_data, exp_d);
                else passed++;
            end
        end
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL wr_rd_drain: %0d missing want 0", sb.size());
        else passed++;
        resp_ready = 1'b0;
    endtask

    // Two writes with different masks, then a read.
    task automatic test_masked_write();
        bit            ok1, ok2, ok3;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] got = '0;
        issue_write(9, 4'hF, 4'hF, ok1);
        issue_write(9, 4'h0, 4'h3, ok2);
        issue_read(9, ok3);
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step();
            if (obs_resp) begin
                checks++;
                got   = obs_resp_data;
                exp_d = sb.pop_front();
                if (obs_resp_data !== exp_d) $display("[TB] FAIL mask_resp: got %h want %h", obs_resp_data, exp_d);
                else passed++;
            end
        end
        checks++;
        if (!(ok1 && ok2 && ok3) || got !== 4'hC) $display("[TB] FAIL mask_value: got %h acc=%b%b%b want c acc=111", got, ok1, ok2, ok3);
        else passed++;
        resp_ready = 1'b0;
    endtask

    // Both channels held valid after reset: grants alternate starting with write.
    task automatic test_back_to_back();
        bit            ok;
        logic [DW-1:0] exp_d;
        do_reset();
        wait_init(ok);
        checks++;
        if (!ok) $display("[TB] FAIL b2b_init: init_done=%b want 1", obs_init);
        else passed++;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = 7'd20;
        rd_addr  = 7'd20;
        wr_mask  = 4'hF;
        for (int i = 0; i < 6; i++) begin
            wr_data = 4'(i + 1);
            step();
            checks++;
            if (obs_wr_acc !== (i % 2 == 0) || obs_rd_acc !== (i % 2 == 1))
                $display("[TB] FAIL b2b_grant%0d: got wr=%b rd=%b want wr=%b rd=%b", i, obs_wr_acc, obs_rd_acc, i % 2 == 0, i % 2 == 1);
            else passed++;
        end
        wr_valid   = 1'b0;
        rd_valid   = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            step();
            if (obs_resp) begin
                checks++;
                exp_d = sb.pop_front();
                if (obs_resp_data !== exp_d) $display("[TB] FAIL b2b_resp: got %h want %h", obs_resp_data, exp_d);
                else passed++;
            end
        end
        checks++;
        if (sb.size() != 0) $display("[TB] FAIL b2b_drain: %0d missing want 0", sb.size());
        else passed++;
        resp_ready = 1'b0;
    endtask

    // Credit throttling with resp_ready low, then recovery.
    task automatic test_throttle();
        int            addrs [5] = '{20, 5, 9, 1, 2};
        int            n = 0;
        logic [DW-1:0] exp_d;
        resp_ready = 1'b0;
        rd_valid   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 7'(addrs[n]);
            step();
            if (obs_rd_acc) n++;
        end
        checks++;
        if (n != 3 || obs_rd_rdy !== 1'b0) $display("[TB] FAIL throttle_stall: accepted %0d rd_ready=%b want 3 and 0", n, obs_rd_rdy);
        else passed++;
        resp_ready = 1'b1;
        for (int i = 0; i < 40 && !(n == 5 && sb.size() == 0); i++) begin
            rd_valid = (n < 5);
            rd_addr  = (n < 5) ? 7'(addrs[n]) : 7'd0;
            step();
            if (obs_rd_acc) n++;
            if (obs_resp) begin
                checks++;
                if (sb.size() == 0) $display("[TB] FAIL throttle_resp: unexpected %h want none", obs_resp_data);
                else begin
                    exp_d = sb.pop_front();
                    if (obs_resp_data !== exp_d) $display("[TB] FAIL throttle_resp: got %h want %h", obs_resp_data, exp_d);
                    else passed++;
                end
            end
        end
        rd_valid = 1'b0;
        checks++;
        if (n != 5 || sb.size() != 0) $display("[TB] FAIL throttle_done: accepted %0d pending %0d want 5 and 0", n, sb.size());
        else passed++;
        resp_ready = 1'b0;
    endtask

    // Reset with 2 responses buffered and 1 read in flight.
    task automatic test_reset_midop();
        int n = 0;
        int first = 0;
        bit ok;
        resp_ready = 1'b0;
        rd_valid   = 1'b1;
        for (int i = 0; i < 10 && n < 3; i++) begin
            rd_addr = 7'(30 + n);
            step();
            if (obs_rd_acc) begin
                if (n == 0) first = obs_cycle;
                n++;
            end
        end
        checks++;
        if (n != 3 || obs_cycle != first + 2) $display("[TB] FAIL midop_setup: accepted %0d span %0d want 3 and 2", n, obs_cycle - first);
        else passed++;
        rd_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cycle   = 1;
        sb.delete();
`ifdef SRAM_INIT_CLEAR_EN
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = '0;
`endif
        step();
        checks++;
        if (obs_resp_valid !== 1'b0 || obs_init !== 1'b0) $display("[TB] FAIL midop_resp: v=%b init=%b want 0 0", obs_resp_valid, obs_init);
        else passed++;
`ifdef SRAM_INIT_CLEAR_EN
        checks++;
        if (obs_en !== 1'b1 || obs_addr !== 7'd0) $display("[TB] FAIL midop_sweep0: en=%b addr=%0d want 1 0", obs_en, obs_addr);
        else passed++;
        step();
        checks++;
        if (obs_en !== 1'b1 || obs_addr !== 7'd1) $display("[TB] FAIL midop_sweep1: en=%b addr=%0d want 1 1", obs_en, obs_addr);
        else passed++;
`else
        checks++;
        if (obs_en !== 1'b0) $display("[TB] FAIL midop_idle: en=%b want 0", obs_en);
        else passed++;
`endif
        wait_init(ok);
        checks++;
        if (!ok) $display("[TB] FAIL midop_init: init_done=%b want 1", obs_init);
        else passed++;
        resp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_resp_valid) ok = 1'b1;
        end
        checks++;
        if (ok) $display("[TB] FAIL midop_stale: stale response seen=%b want 0", ok);
        else passed++;
        resp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = junk(i);
        $display("[TB] start, expected init cycle %0d", INIT_CYCLE);
        test_reset();
        test_init();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_throttle();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_rw0_initiator.md
# sram_rw0_initiator

Initiator for the single-port RW0 SRAM macro interface: address, enable, write mode, write mask and write data, with read data returned one cycle after a read. It accepts independent write and read request channels using valid/ready handshakes and arbitrates them round-robin onto the one RW0 port. Read data is captured into a small response FIFO, and reads are credit-throttled so that no returned read data is lost. It sits between L2 pipeline stages and the array macros, and can optionally zero the whole array after reset.

## Interface
- ADDR_W, 7, RW0 address width; depth = 2^ADDR_W
- DATA_W, 4, data and mask width
- clock  in  1  sole clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- wr_valid / wr_ready  in / out  1  write request handshake
- wr_addr  in  ADDR_W; wr_data  in  DATA_W; wr_mask  in  DATA_W  (bit=1 writes that bit)
- rd_valid / rd_ready  in / out  1  read request handshake
- rd_addr  in  ADDR_W
- resp_valid / resp_ready  out / in  1  read response handshake
- resp_data  out  DATA_W  read data, returned in request order
- init_done  out  1  array usable; request channels stay blocked while this is 0
- RW0_en, RW0_wmode  out  1; RW0_addr  out  ADDR_W; RW0_wmask, RW0_wdata  out  DATA_W
- RW0_rdata  in  DATA_W  valid in the cycle after a read issue

## Operation
- States: INIT and RUN. Reset enters INIT (see Configuration).
- At most one RW0 access per cycle. The granted request drives RW0 combinationally in the same cycle it is accepted.
- When RW0_en=0, all RW0 outputs are 0.
- Eligibility in RUN:
  - Write is eligible when wr_valid=1.
  - Read is eligible when rd_valid=1 and fifo_count + inflight < 3.
- Grant:
  - If only one channel is eligible, it is granted.
  - If both are eligible, the channel holding the priority bit is granted.
  - After any grant, priority moves to the other channel.
  - Priority resets to write.
- wr_ready and rd_ready are high only for the granted channel. They may depend combinationally on wr_valid and rd_valid. They are never high outside RUN.
- Write accept: RW0_en=1, RW0_wmode=1, and addr, mask and data are passed straight through.
- Read accept in cycle T: RW0_en=1, RW0_wmode=0, and inflight is set for cycle T+1. At the end of T+1, RW0_rdata is pushed into the 3-entry response FIFO.
- FIFO:
  - resp_valid = (count != 0) and resp_data = head entry.
  - A pop happens on resp_valid && resp_ready.
  - A simultaneous push and pop leaves count unchanged.
  - The credit rule guarantees the FIFO never overflows.
- Ordering: a write at cycle T followed by a read of the same address at T+1 returns the new data. Requests on both channels are performed in grant order.
- Reset mid-operation (reset_n=0 sampled at any edge):
  - FIFO, inflight and priority are cleared.
  - In-flight read data is discarded, and any INIT sweep restarts from address 0.

## Timing
- Reset values: all RW0 outputs 0, wr_ready=rd_ready=0, resp_valid=0, resp_data=0, init_done=0.
- Read latency from accept (cycle T) to resp_valid is 2 cycles (cycle T+2).
- Throughput with resp_ready held high: one read per cycle sustained, no bubbles.
- With resp_ready=0: at most 3 reads are accepted, then rd_ready stays low until a pop frees a credit.
- The FIFO is a plain 3-entry buffer with no bypass, so resp_valid never depends combinationally on resp_ready.

## Configuration
- SRAM_INIT_CLEAR_EN defined:
  - INIT sweeps addresses 0 to 2^ADDR_W-1, one per cycle, with RW0_en=1, RW0_wmode=1, RW0_wmask=all ones and RW0_wdata=0.
  - After the last address, the state moves to RUN and init_done rises. For ADDR_W=7 this is in the 129th cycle after reset release.
- SRAM_INIT_CLEAR_EN undefined:
  - INIT lasts exactly one cycle with RW0 idle.
  - init_done=1 from the second cycle after reset release.

## Structure
- Package sram_rw0_pkg holds:
  - the state enum (INIT, RUN)
  - localparam RESP_DEPTH=3
  - the credit-limit constant
- Sub-module sram_rw0_resp_fifo: 3-entry synchronous FIFO with push, pop and count. The parent instantiates it and derives credits from count.
- The arbiter, the INIT sweep counter (ADDR_W+1 bits) and the inflight flag live in the top module.

## Test plan
- Clear enabled: release reset, then read addresses 0, 64 and 127. Required: init_done at cycle 129, no request accepted before it, and all three responses are 0x0.
- Write addr 5, data 0xA, mask 0xF, then read addr 5 in the next cycle. Required: response 0xA two cycles after the read accept.
- Masked write: write 0xF to addr 9 with mask 0xF, then write 0x0 with mask 0x3, then read addr 9. Required: response 0xC.
- Hold both channels valid for 6 cycles. Required: grants alternate W, R, W, R, W, R, starting with write.
- Hold resp_ready=0 and issue 5 reads. Required: exactly 3 accepted and rd_ready=0 afterwards. Then raise resp_ready: the 3 responses arrive in order and the remaining 2 reads complete.
- Pull reset_n low for one cycle while 2 responses are pending and 1 read is in flight. Required: resp_valid=0 after reset, no stale data is delivered, and the INIT sweep restarts at address 0.
